seg7_capture: RTL and testbench

Receive-side counterpart of the typing game's hex-to-seven-segment encoder. Samples a scanned, active-low seven-segment bus (segment lines plus digit selects), filters glitches by requiring a stable pattern across consecutive samples, and decodes each digit back to a 4-bit value with valid and blank flags. Used for display readback and self-check of the scoreboard/letter display path.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_pattern_decode.sv | 41 ++++
 rtl/seg7_capture.sv | 136 +++++++++++++
 tb/tb_seg7_capture.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants, capture FSM state type and select-line helper.
// Segment patterns are active-low, packed g..a (bit6..bit0).
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } cap_state_e;

  // Index of the low bit in a one-hot-low select; callers check legality separately.
  function automatic logic [2:0] onehot_low_idx(input logic [7:0] sel_n);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (!sel_n[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment pattern to nibble decoder (active-low segments).
// Flags hex glyphs and the all-off pattern; anything else is neither.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] nibble_o,
  output logic       is_hex_o,
  output logic       is_blank_o
);

  always_comb begin
    nibble_o   = '0;
    is_hex_o   = 1'b1;
    is_blank_o = 1'b0;
    case (seg_n_i)
      SEG_0:     nibble_o = 4'h0;
      SEG_1:     nibble_o = 4'h1;
      SEG_2:     nibble_o = 4'h2;
      SEG_3:     nibble_o = 4'h3;
      SEG_4:     nibble_o = 4'h4;
      SEG_5:     nibble_o = 4'h5;
      SEG_6:     nibble_o = 4'h6;
      SEG_7:     nibble_o = 4'h7;
      SEG_8:     nibble_o = 4'h8;
      SEG_9:     nibble_o = 4'h9;
      SEG_A:     nibble_o = 4'hA;
      SEG_B:     nibble_o = 4'hB;
      SEG_C:     nibble_o = 4'hC;
      SEG_D:     nibble_o = 4'hD;
      SEG_E:     nibble_o = 4'hE;
      SEG_F:     nibble_o = 4'hF;
      SEG_BLANK: begin
        is_hex_o   = 1'b0;
        is_blank_o = 1'b1;
      end
      default:   is_hex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Scanned seven-segment bus capture: debounces each digit's pattern and decodes it back to hex.
// Optional SEGCAP_ERR_CNT_EN adds a saturating 8-bit count of unknown-pattern commits.
//
// state  | meaning
// IDLE   | no candidate held (after reset or an illegal select sample)
// TRACK  | candidate held, counting consecutive matching samples
// LOCKED | candidate committed; matching samples ignored until it changes
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    upd,
  output logic [2:0]              upd_idx,
  output logic                    err
`ifdef SEGCAP_ERR_CNT_EN
  ,
  output logic [7:0]              err_cnt
`endif
);

  localparam logic [3:0] CNT_TGT = 4'(STABLE_CNT);

  cap_state_e              state_q;
  logic [2:0]              cand_idx_q;
  logic [6:0]              cand_seg_q;
  logic [3:0]              cnt_q;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic [NUM_DIGITS-1:0]   blank_q;
  logic                    upd_q;
  logic [2:0]              upd_idx_q;
  logic                    err_q;

  logic [7:0] an_pad_d;
  logic       legal_d;
  logic [2:0] samp_idx_d;
  logic       match_d;
  logic [3:0] cnt_inc_d;
  logic [3:0] dec_nibble;
  logic       dec_is_hex;
  logic       dec_is_blank;

  seg7_pattern_decode u_decode (
    .seg_n_i    (seg_n),
    .nibble_o   (dec_nibble),
    .is_hex_o   (dec_is_hex),
    .is_blank_o (dec_is_blank)
  );

  always_comb begin
    an_pad_d                   = '1;
    an_pad_d[NUM_DIGITS-1:0]   = an_n;
  end

  assign legal_d    = sample_en && ($countones(an_n) == NUM_DIGITS - 1);
  assign samp_idx_d = onehot_low_idx(an_pad_d);
  assign match_d    = (state_q != IDLE) && (samp_idx_d == cand_idx_q) && (seg_n == cand_seg_q);
  assign cnt_inc_d  = cnt_q + 4'd1;

`ifdef SEGCAP_ERR_CNT_EN
  logic [7:0] err_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cand_idx_q <= '0;
      cand_seg_q <= '1;
      cnt_q      <= '0;
      digits_q   <= '0;
      valid_q    <= '0;
      blank_q    <= '0;
      upd_q      <= 1'b0;
      upd_idx_q  <= '0;
      err_q      <= 1'b0;
`ifdef SEGCAP_ERR_CNT_EN
      err_cnt_q  <= '0;
`endif
    end else begin
      upd_q <= 1'b0;
      err_q <= 1'b0;
      if (sample_en) begin
        if (!legal_d) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else if ((state_q == IDLE) || !match_d) begin
          state_q    <= TRACK;
          cand_idx_q <= samp_idx_d;
          cand_seg_q <= seg_n;
          cnt_q      <= 4'd1;
        end else if (state_q == TRACK) begin
          cnt_q <= cnt_inc_d;
          if (cnt_inc_d == CNT_TGT) begin
            state_q   <= LOCKED;
            upd_q     <= 1'b1;
            upd_idx_q <= samp_idx_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (samp_idx_d == 3'(i)) begin
                valid_q[i] <= dec_is_hex;
                blank_q[i] <= dec_is_blank;
                if (dec_is_hex)        digits_q[4*i +: 4] <= dec_nibble;
                else if (dec_is_blank) digits_q[4*i +: 4] <= 4'h0;
              end
            end
            // Unknown glyph: digit value kept, only the flags drop.
            if (!dec_is_hex && !dec_is_blank) begin
              err_q <= 1'b1;
`ifdef SEGCAP_ERR_CNT_EN
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
`endif
            end
          end
        end
      end
    end
  end

  assign digits  = digits_q;
  assign valid   = valid_q;
  assign blank   = blank_q;
  assign upd     = upd_q;
  assign upd_idx = upd_idx_q;
  assign err     = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: run-length reference model checked every cycle, directed
// scenarios with literal expectations, then randomized bursts with occasional resets.
module tb_seg7_capture;

  localparam int ND = 4;
  localparam int SC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_en;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] valid;
  logic [ND-1:0] blank;
  logic          upd;
  logic [2:0]    upd_idx;
  logic          err;
`ifdef SEGCAP_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .digits    (digits),
    .valid     (valid),
    .blank     (blank),
    .upd       (upd),
    .upd_idx   (upd_idx),
    .err       (err)
`ifdef SEGCAP_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  logic [6:0] pat [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: outputs follow from the length of the current run of identical legal samples.
  logic [4*ND-1:0] m_digits;
  logic [ND-1:0]   m_valid, m_blank;
  logic            m_upd, m_err;
  logic [2:0]      m_idx;
  int              m_errcnt;
  int              run_len, run_idx;
  logic [6:0]      run_seg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int glyph(input logic [6:0] s);
    int v;
    v = -1;
    for (int k = 0; k < 16; k++) if (pat[k] == s) v = k;
    if (s == 7'h7F) v = 16;
    return v;
  endfunction

  always @(posedge clk) begin
    int zeros, idx, g;
    m_upd = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_digits = '0; m_valid = '0; m_blank = '0; m_idx = '0;
      m_errcnt = 0; run_len = 0; run_idx = 0; run_seg = '1;
    end else if (sample_en) begin
      zeros = 0; idx = 0;
      for (int k = 0; k < ND; k++) if (!an_n[k]) begin zeros++; idx = k; end
      if (zeros != 1) run_len = 0;
      else begin
        if (run_len > 0 && idx == run_idx && seg_n == run_seg) begin
          if (run_len < 1000) run_len++;
        end else begin
          run_idx = idx; run_seg = seg_n; run_len = 1;
        end
        if (run_len == SC) begin
          g = glyph(seg_n);
          m_upd = 1'b1;
          m_idx = 3'(idx);
          if (g >= 0 && g < 16) begin
            m_digits[4*idx +: 4] = 4'(g); m_valid[idx] = 1'b1; m_blank[idx] = 1'b0;
          end else if (g == 16) begin
            m_digits[4*idx +: 4] = 4'h0; m_valid[idx] = 1'b0; m_blank[idx] = 1'b1;
          end else begin
            m_valid[idx] = 1'b0; m_blank[idx] = 1'b0; m_err = 1'b1;
            if (m_errcnt < 255) m_errcnt++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("digits", 32'(digits), 32'(m_digits));
      check("valid", 32'(valid), 32'(m_valid));
      check("blank", 32'(blank), 32'(m_blank));
      check("upd", 32'(upd), 32'(m_upd));
      check("err", 32'(err), 32'(m_err));
      if (m_upd) check("upd_idx", 32'(upd_idx), 32'(m_idx));
`ifdef SEGCAP_ERR_CNT_EN
      check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
    end
  end

  task automatic step(input logic r, input logic en, input logic [ND-1:0] an, input logic [6:0] seg);
    rst = r; sample_en = en; an_n = an; seg_n = seg;
    @(posedge clk);
    #1;
  endtask

  task automatic samples(input logic [ND-1:0] an, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, an, seg);
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; an_n = '1; seg_n = '1;
    @(posedge clk); @(posedge clk); #1;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    check("rst_upd", 32'(upd), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    chk_on = 1'b1;

    samples(4'b1110, 7'b0100100, 3);
    check("d0_is_2", 32'(digits[3:0]), 32'h2);
    check("valid_0001", 32'(valid), 32'b0001);
    check("upd_pulse", 32'(upd), 32'h1);
    check("upd_idx0", 32'(upd_idx), 32'h0);
    step(1'b0, 1'b0, 4'b1110, 7'b0100100);
    check("upd_one_cycle", 32'(upd), 32'h0);

    samples(4'b1101, 7'b0001000, 2);
    samples(4'b1101, 7'b0000011, 1);
    samples(4'b1101, 7'b0001000, 2);
    check("glitch_no_commit", 32'(upd), 32'h0);
    step(1'b0, 1'b0, 4'b1101, 7'b0001000);
    samples(4'b1101, 7'b0001000, 1);
    check("d1_is_A", 32'(digits[7:4]), 32'hA);

    samples(4'b1100, 7'b0000000, 5);
    samples(4'b1110, 7'b0000000, 2);
    check("illegal_no_upd", 32'(upd), 32'h0);
    samples(4'b1110, 7'b0000000, 1);
    check("d0_is_8", 32'(digits[3:0]), 32'h8);

    samples(4'b1011, 7'b1111111, 3);
    check("blank_0100", 32'(blank), 32'b0100);
    check("valid_0011", 32'(valid), 32'b0011);
    check("d2_zero", 32'(digits[11:8]), 32'h0);

    samples(4'b0111, 7'b0101010, 3);
    check("err_pulse", 32'(err), 32'h1);
    check("valid3_low", 32'(valid[3]), 32'h0);
`ifdef SEGCAP_ERR_CNT_EN
    check("err_cnt_1", 32'(err_cnt), 32'h1);
`endif

    samples(4'b1110, 7'b1111000, 2);
    step(1'b1, 1'b1, 4'b1110, 7'b1111000);
    samples(4'b1110, 7'b1111000, 2);
    check("rst_drops_run", 32'(upd), 32'h0);
    samples(4'b1110, 7'b1111000, 1);
    check("d0_is_7", 32'(digits[3:0]), 32'h7);

    for (int b = 0; b < 700; b++) begin
      logic [ND-1:0] an;
      logic [6:0]    seg;
      int            r, len;
      an = ~(ND'(1) << $urandom_range(0, ND - 1));
      if ($urandom_range(0, 9) == 0) an = ND'($urandom_range(0, (1 << ND) - 1));
      r = $urandom_range(0, 19);
      if (r < 16)       seg = pat[r];
      else if (r == 16) seg = 7'h7F;
      else              seg = 7'($urandom);
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++)
        step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), an, seg);
    end

`ifdef SEGCAP_ERR_CNT_EN
    for (int k = 0; k < 300; k++) samples((k % 2 == 0) ? 4'b0111 : 4'b1011, 7'b0101010, 3);
    check("err_cnt_sat", 32'(err_cnt), 32'd255);
`endif

    step(1'b0, 1'b0, '1, '1);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
